// File: rtl/bk_slice_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bk_slice_add_seq
//  Purpose  : Multi-cycle WIDTH-bit add/subtract sequencer. It drives one
//             shared, external, combinational SLICE-bit Brent-Kung adder core
//             over NSLICE cycles. Slices go least-significant first, and the
//             inter-slice carry ripples through a register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      rising-edge clock
//    rst_n        in   1      asynchronous active-low reset
//    start_valid  in   1      request valid
//    start_ready  out  1      block can accept a request (IDLE)
//    op_a         in   WIDTH  minuend / addend A
//    op_b         in   WIDTH  subtrahend / addend B
//    sub          in   1      1 = A-B, 0 = A+B
//    add_a        out  SLICE  slice operand A to the adder core
//    add_b        out  SLICE  slice operand B to the adder core (inverted for sub)
//    add_cin      out  1      carry-in to the adder core
//    add_sum      in   SLICE  adder core sum
//    add_cout     in   1      adder core carry-out
//    res_valid    out  1      result valid (DONE)
//    res_ready    in   1      consumer accepts the result
//    result       out  WIDTH  sum or difference mod 2^WIDTH
//    carry_out    out  1      final carry; for sub, 1 = no borrow
//    busy         out  1      state != IDLE
// ============================================================================
module bk_slice_add_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SLICE = CNT_W'(NSLICE - 1);

    // Reject configurations where the slices would not tile the operand.
    if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("bk_slice_add_seq: WIDTH must be a positive multiple of SLICE");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             sub_q,       sub_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_out_q, carry_out_d;

    // Bit offset of the slice currently being processed.
    int unsigned slice_base;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and adder-core drive
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        slice_base  = int'(cnt_q) * SLICE;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d         = op_a;
                    b_d         = op_b;
                    sub_d       = sub;
                    // Subtraction is A + ~B + 1: the +1 enters as the first carry-in.
                    carry_d     = sub;
                    cnt_d       = '0;
                    // Cleared so a partially built result never exposes the old one.
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                add_a   = a_q[slice_base +: SLICE];
                add_b   = b_q[slice_base +: SLICE] ^ {SLICE{sub_q}};
                add_cin = carry_q;
                // The core's outputs are only consumed here, so X on them
                // elsewhere cannot reach any register.
                result_d[slice_base +: SLICE] = add_sum;
                carry_d = add_cout;
                if (cnt_q == C_LAST_SLICE) begin
                    carry_out_d = add_cout;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                // A start seen in this cycle is not accepted: start_ready
                // only rises once back in IDLE.
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // start_ready is qualified with rst_n so it stays low while reset is held.
    assign start_ready = (state_q == ST_IDLE) && rst_n;
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign result      = result_q;
    assign carry_out   = carry_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bk_slice_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bk_slice_add_seq
//  Purpose  : Directed self-checking bench for bk_slice_add_seq with a
//             behavioural 8-bit adder core closing the loop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bk_slice_add_seq;

    localparam int WIDTH  = 64;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic [SLICE-1:0] add_a;
    logic [SLICE-1:0] add_b;
    logic             add_cin;
    logic [SLICE-1:0] add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             busy;

    int n_checks;
    int n_errors;

    logic [NSLICE-1:0] cin_seq;
    logic [SLICE-1:0]  first_add_b;
    logic              first_add_cin;

    bk_slice_add_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .busy        (busy)
    );

    // Behavioural stand-in for the external combinational slice adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request from IDLE and step through RUN, leaving the DUT in
    // DONE at a negedge. Records per-slice carry-ins and the first add_b.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [WIDTH-1:0] exp_res, input logic exp_c);
        check({tag, ".ready"}, 64'(start_ready), 64'd1);
        op_a        = a;
        op_b        = b;
        sub         = s;
        start_valid = 1'b1;
        @(posedge clk);               // accepting edge
        @(negedge clk);
        start_valid = 1'b0;
        op_a        = $urandom();
        op_b        = $urandom();
        check({tag, ".cleared"}, result, 64'd0);
        for (int k = 0; k < NSLICE; k++) begin
            if (k == 0) begin
                first_add_b   = add_b;
                first_add_cin = add_cin;
            end
            cin_seq[k] = add_cin;
            if (k == NSLICE - 1) check({tag, ".early_valid"}, 64'(res_valid), 64'd0);
            @(negedge clk);
        end
        check({tag, ".valid"},  64'(res_valid), 64'd1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".carry"},  64'(carry_out), 64'(exp_c));
    endtask

    task automatic retire();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        sub         = 1'b0;

        // ---------------- Reset with random inputs, asserted mid-cycle
        repeat (2) begin
            @(negedge clk);
            start_valid = 1'($urandom());
            res_ready   = 1'($urandom());
            op_a        = {$urandom(), $urandom()};
            op_b        = {$urandom(), $urandom()};
            sub         = 1'($urandom());
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst.busy",      64'(busy),      64'd0);
        check("rst.res_valid", 64'(res_valid), 64'd0);
        check("rst.result",    result,         64'd0);
        check("rst.carry_out", 64'(carry_out), 64'd0);
        check("rst.add_a",     64'(add_a),     64'd0);
        check("rst.add_b",     64'(add_b),     64'd0);
        check("rst.add_cin",   64'(add_cin),   64'd0);
        @(negedge clk);
        start_valid = 1'b0;
        res_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);

        // ---------------- Add with full ripple
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
        check("ripple.cin_seq", 64'(cin_seq), 64'h0000_0000_0000_00FE);
        retire();
        check("ripple.idle", 64'(busy), 64'd0);

        // ---------------- Subtract with borrow
        run_op("sub_borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check("sub_borrow.add_b0",   64'(first_add_b),   64'h0000_0000_0000_00F8);
        check("sub_borrow.add_cin0", 64'(first_add_cin), 64'd1);
        retire();

        // ---------------- Subtract with no borrow across slices
        run_op("sub_nb", 64'h100, 64'd1, 1'b1, 64'h0000_0000_0000_00FF, 1'b1);

        // ---------------- Backpressure in DONE with a competing start
        start_valid = 1'b1;
        op_a        = 64'h1111;
        op_b        = 64'h2222;
        sub         = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp.result",      result,           64'h0000_0000_0000_00FF);
            check("bp.carry",       64'(carry_out),   64'd1);
            check("bp.start_ready", 64'(start_ready), 64'd0);
            check("bp.res_valid",   64'(res_valid),   64'd1);
        end
        // res_ready and start_valid together in DONE: start must not be taken.
        res_ready = 1'b1;
        @(negedge clk);
        res_ready   = 1'b0;
        start_valid = 1'b0;
        check("bp.res_valid_drop", 64'(res_valid), 64'd0);
        check("bp.not_accepted",   64'(busy),      64'd0);
        @(negedge clk);
        check("bp.still_idle",     64'(busy),      64'd0);
        run_op("reissue", 64'h1111, 64'h2222, 1'b0, 64'h3333, 1'b0);
        retire();

        // ---------------- Reset mid-RUN at counter 3
        op_a        = 64'hDEAD_BEEF_0000_1234;
        op_b        = 64'h0123_4567_89AB_CDEF;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun.add_a3", 64'(add_a), 64'h0000_0000_0000_0000);
        #2 rst_n = 1'b0;
        #1;
        check("midrun.busy",      64'(busy),      64'd0);
        check("midrun.res_valid", 64'(res_valid), 64'd0);
        check("midrun.result",    result,         64'd0);
        check("midrun.carry_out", 64'(carry_out), 64'd0);
        check("midrun.add_b",     64'(add_b),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0);
        retire();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
